// File: rtl/core_pkg.sv
// core_pkg: shared result-select and memory-stage FSM encodings.
package core_pkg;
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  typedef enum logic [1:0] {MEM_IDLE, MEM_REQ, MEM_RESP} memState_t;
endpackage

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory req/gnt/rvalid handshake, pipeline stall and load-data capture.
module dmem_ctrl import core_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              store,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall,
  output logic [DATA_W-1:0] readData
);
  memState_t state, nextState;
  logic access, done, loadDone;
  always_ff @(posedge clk)
    state <= !rst ? MEM_IDLE : nextState;
  // Address/data come straight from the held EX/MEM register, so they stay stable in REQ.
  always_comb begin
    access = load | store;
    loadDone = (state == MEM_RESP) & dmem_rvalid;
    done = ((state != MEM_RESP) & store & dmem_gnt) | loadDone;
    dmem_req = (state == MEM_REQ) | ((state == MEM_IDLE) & access);
    dmem_we = store;
    dmem_addr = addr;
    dmem_wdata = wdata;
    stall = (state == MEM_IDLE) ? access & ~done : ~done;
    readData = loadDone ? dmem_rdata : '0;
    nextState = (state == MEM_IDLE) ? (access & ~dmem_gnt ? MEM_REQ :
                                       load & dmem_gnt ? MEM_RESP : MEM_IDLE) :
                (state == MEM_REQ)  ? (dmem_gnt ? (store ? MEM_IDLE : MEM_RESP) : MEM_REQ) :
                                      (dmem_rvalid ? MEM_IDLE : MEM_RESP);
  end
endmodule

// File: rtl/memory_cycle.sv
// memory_cycle: RV32 memory stage with MEM/WB register.
// MEM_MISALIGN_CHECK_EN suppresses misaligned accesses and flags them in MisalignW.
module memory_cycle import core_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic [1:0]        ResultSrcM,
  input  logic [4:0]        RD_M,
  input  logic [ADDR_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [31:0]       PCPlus4M,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              StallM,
  output logic              RegWriteW,
  output logic [1:0]        ResultSrcW,
  output logic [4:0]        RD_W,
  output logic [DATA_W-1:0] ALUResultW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [31:0]       PCPlus4W,
  output logic              MisalignW
);
  logic load, store, misalign;
  logic [DATA_W-1:0] readData;
  assign load = (ResultSrcM == RES_MEM) & ~MemWriteM;
  assign store = MemWriteM;
`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign = (load | store) & (|ALUResultM[1:0]);
`else
  assign misalign = 1'b0;
`endif
  dmem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ctrl (
    .clk(clk),
    .rst(rst),
    .load(load & ~misalign),
    .store(store & ~misalign),
    .addr(ALUResultM),
    .wdata(WriteDataM),
    .dmem_req(dmem_req),
    .dmem_we(dmem_we),
    .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata),
    .stall(StallM),
    .readData(readData)
  );
  // A stalled cycle hands writeback a bubble.
  always_ff @(posedge clk)
    if (!rst || StallM) begin
      RegWriteW <= 1'b0;
      ResultSrcW <= '0;
      RD_W <= '0;
      ALUResultW <= '0;
      ReadDataW <= '0;
      PCPlus4W <= '0;
      MisalignW <= 1'b0;
    end else begin
      RegWriteW <= RegWriteM & ~misalign;
      ResultSrcW <= ResultSrcM;
      RD_W <= RD_M;
      ALUResultW <= DATA_W'(ALUResultM);
      ReadDataW <= readData;
      PCPlus4W <= PCPlus4M;
      MisalignW <= misalign;
    end
endmodule
